// File: rtl/bcd_display_mux.sv
// Three-digit multiplexed seven-segment driver for captured BCD hundreds/tens/units.
// Latency: seg/an are registered, reflecting state and held digits from the previous edge (1 cycle).
// No backpressure: cargar is always accepted; the scan free-runs off a REFRESH_DIV prescaler.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] unos,
  input  logic [3:0] dieces,
  input  logic [3:0] cientos,
  input  logic       cargar,
  input  logic       blank_ceros,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] digito_activo
);

  // Prescaler width; a divider of 1 still needs a one-bit counter that stays at 0.
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Scan states; the encoding doubles as the active digit index.
  localparam logic [1:0] ST_UNOS    = 2'd0;
  localparam logic [1:0] ST_DIECES  = 2'd1;
  localparam logic [1:0] ST_CIENTOS = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  logic [3:0]       hold_unos;
  logic [3:0]       hold_dieces;
  logic [3:0]       hold_cientos;
  logic [CNT_W-1:0] presc;
  logic             tick;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       digit_sel;
  logic             blank;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;

  // BCD to seven-segment; codes above 9 show a dash so bad data is visible.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Capture the digits only on cargar; the display never looks at the live inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_unos    <= 4'd0;
      hold_dieces  <= 4'd0;
      hold_cientos <= 4'd0;
    end else if (cargar) begin
      hold_unos    <= unos;
      hold_dieces  <= dieces;
      hold_cientos <= cientos;
    end
  end

  // Terminal count of the prescaler marks the end of one digit's dwell.
  assign tick = (presc == CNT_LAST);

  // Prescaler counts 0..REFRESH_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  // Next scan state: rotate units -> tens -> hundreds on each tick; recover from the unused code.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNOS:    if (tick) state_nxt = ST_DIECES;
      ST_DIECES:  if (tick) state_nxt = ST_CIENTOS;
      ST_CIENTOS: if (tick) state_nxt = ST_UNOS;
      default:    state_nxt = ST_UNOS;
    endcase
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_UNOS;
    end else begin
      state <= state_nxt;
    end
  end

  assign digito_activo = state;

  // Select the active digit and decide leading-zero blanking; only true zeros blank, not invalid codes.
  always_comb begin
    digit_sel = hold_unos;
    blank     = 1'b0;
    an_nxt    = AN_OFF;
    case (state)
      ST_UNOS: begin
        digit_sel = hold_unos;
        an_nxt    = 4'b1110;
      end
      ST_DIECES: begin
        digit_sel = hold_dieces;
        an_nxt    = 4'b1101;
        blank     = blank_ceros && (hold_cientos == 4'd0) && (hold_dieces == 4'd0);
      end
      ST_CIENTOS: begin
        digit_sel = hold_cientos;
        an_nxt    = 4'b1011;
        blank     = blank_ceros && (hold_cientos == 4'd0);
      end
      ST_ILLEGAL: begin
        blank = 1'b1;
      end
      default: begin
        blank = 1'b1;
      end
    endcase
    if (blank) begin
      an_nxt  = AN_OFF;
      seg_nxt = SEG_OFF;
    end else begin
      seg_nxt = decode(digit_sel);
    end
  end

  // Registered drivers so segments and anodes switch together, glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomised and directed scan of bcd_display_mux against a cycle-count model.
// Expected outputs are queued by the driver and popped by an independent monitor.
// The DUT has no backpressure; one expectation is consumed per clock edge.
module tb_bcd_display_mux;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic [3:0] unos;
  logic [3:0] dieces;
  logic [3:0] cientos;
  logic       cargar;
  logic       blank_ceros;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digito_activo;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] dig;
  } exp_t;

  exp_t       exp_q[$];
  int         checks;
  int         errors;
  int         k;
  logic [3:0] mh[3];
  logic [6:0] seg_tbl[10];
  logic       cur_bz;

  bcd_display_mux #(.REFRESH_DIV(DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .unos          (unos),
    .dieces        (dieces),
    .cientos       (cientos),
    .cargar        (cargar),
    .blank_ceros   (blank_ceros),
    .seg           (seg),
    .an            (an),
    .digito_activo (digito_activo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display for a slot, from the held digits and the blanking rule.
  function automatic exp_t disp(input int slot, input logic bz);
    exp_t       e;
    logic [3:0] v;
    logic       blank;
    v     = mh[slot];
    blank = bz && ((slot == 2 && mh[2] == 4'd0) ||
                   (slot == 1 && mh[2] == 4'd0 && mh[1] == 4'd0));
    e.dig = 2'd0;
    if (blank) begin
      e.seg = 7'b1111111;
      e.an  = 4'b1111;
    end else begin
      e.seg = (v <= 4'd9) ? seg_tbl[v] : 7'b0111111;
      e.an  = 4'b1111;
      e.an[slot] = 1'b0;
    end
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the response the next edge must produce.
  task automatic step(input logic r, input logic c, input logic [3:0] u,
                      input logic [3:0] d, input logic [3:0] h, input logic bz);
    exp_t e;
    @(negedge clk);
    reset       = r;
    cargar      = c;
    unos        = u;
    dieces      = d;
    cientos     = h;
    blank_ceros = bz;
    if (r) begin
      e     = '{seg: 7'b1111111, an: 4'b1111, dig: 2'd0};
      k     = 0;
      mh[0] = 4'd0;
      mh[1] = 4'd0;
      mh[2] = 4'd0;
    end else begin
      e = disp((k / DIV) % 3, bz);
      if (c) begin
        mh[0] = u;
        mh[1] = d;
        mh[2] = h;
      end
      k     = k + 1;
      e.dig = 2'((k / DIV) % 3);
    end
    exp_q.push_back(e);
  endtask

  // Idle cycles with junk on the live digit inputs, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), cur_bz);
  endtask

  task automatic load(input logic [3:0] h, input logic [3:0] d, input logic [3:0] u);
    step(1'b0, 1'b1, u, d, h, cur_bz);
  endtask

  // Monitor: compare every edge's registered outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (seg !== e.seg) begin
          errors++;
          $display("FAIL seg k=%0d: got %b expected %b", k, seg, e.seg);
        end
        checks++;
        if (an !== e.an) begin
          errors++;
          $display("FAIL an k=%0d: got %b expected %b", k, an, e.an);
        end
        checks++;
        if (digito_activo !== e.dig) begin
          errors++;
          $display("FAIL digito_activo k=%0d: got %0d expected %0d", k, digito_activo, e.dig);
        end
      end
    end
  end

  initial begin
    int guard;
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    checks = 0;
    errors = 0;
    k      = 0;
    mh[0]  = 4'd0;
    mh[1]  = 4'd0;
    mh[2]  = 4'd0;
    cur_bz = 1'b0;
    reset = 1'b1; cargar = 1'b0; unos = 4'd0; dieces = 4'd0; cientos = 4'd0; blank_ceros = 1'b0;

    // Reset for two cycles, then the zeroed units digit appears.
    step(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 1'b0);
    step(1'b1, 1'b0, 4'd3, 4'd3, 4'd3, 1'b0);
    idle(13);

    // 2,5,5 cycles through all three slots, four edges each.
    load(4'd2, 4'd5, 4'd5);
    idle(26);

    // Leading-zero blanking on and off with 0,0,7.
    cur_bz = 1'b1;
    load(4'd0, 4'd0, 4'd7);
    idle(14);
    cur_bz = 1'b0;
    idle(14);

    // Invalid units code shows a dash, blanking or not; invalid hundreds is not a zero.
    load(4'd0, 4'd3, 4'hA);
    idle(13);
    cur_bz = 1'b1;
    load(4'd0, 4'd0, 4'hA);
    idle(13);
    load(4'hC, 4'd0, 4'd1);
    idle(13);

    // Reset while the hundreds slot is active; old data must be gone afterwards.
    load(4'd8, 4'd8, 4'd8);
    guard = 0;
    while (((k / DIV) % 3) != 2 && guard < 50) begin
      idle(1);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL reach_hundreds_slot: waited %0d cycles, limit 50", guard);
    end
    idle(1);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, cur_bz);
    idle(13);

    // New data loaded exactly on a tick edge.
    load(4'd1, 4'd2, 4'd3);
    guard = 0;
    while ((k % DIV) != DIV - 1 && guard < 20) begin
      idle(1);
      guard++;
    end
    load(4'd6, 4'd4, 4'd9);
    idle(13);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cur_bz = ~cur_bz;
      if ($urandom_range(0, 79) == 0)
        step(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), cur_bz);
      else if ($urandom_range(0, 7) == 0)
        step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 2)), cur_bz);
      else
        idle(1);
    end

    // Drain: every queued expectation must have been consumed.
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clock cycles each digit is shown (≥1).
REQ-002 Port: clk  input  1  system clock; all logic on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: unos  input  4  BCD units digit from the binary-to-BCD stage.
REQ-005 Port: dieces  input  4  BCD tens digit.
REQ-006 Port: cientos  input  4  BCD hundreds digit.
REQ-007 Port: cargar  input  1  capture strobe; samples unos/dieces/cientos into holding registers.
REQ-008 Port: blank_ceros  input  1  enables leading-zero suppression.
REQ-009 Port: seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 Port: an  output  4  active-low digit anodes; an[0]=units, an[1]=tens, an[2]=hundreds, an[3]=unused.
REQ-011 Port: digito_activo  output  2  index of the digit currently driven (0, 1 or 2).

Function
REQ-012 The block SHALL hold three 4-bit registers loaded from unos/dieces/cientos on any rising edge where cargar=1; otherwise they retain their value.
REQ-013 The display SHALL use only holding-register contents, never the live inputs.
REQ-014 A prescaler SHALL count 0..REFRESH_DIV-1, wrap to 0, and generate a one-cycle tick on the terminal count.
REQ-015 The scan state machine SHALL have states UNOS(0), DIECES(1), CIENTOS(2); on a tick: UNOS->DIECES->CIENTOS->UNOS; no tick: hold.
REQ-016 State 3 SHALL be unreachable; if entered, the next edge SHALL return to UNOS.
REQ-017 digito_activo SHALL equal the current state encoding.
REQ-018 seg and an SHALL be registered: they reflect the state and holding registers from the previous edge (1-cycle latency).
REQ-019 an SHALL drive exactly one low bit for the active digit; an[3] SHALL always be 1.
REQ-020 Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 Codes 10..15 SHALL display a dash: seg=0111111.
REQ-022 With blank_ceros=1: hundreds blanked when hundreds=0; tens blanked when hundreds=0 and tens=0; units are never blanked.
REQ-023 A blanked slot SHALL drive an=1111 and seg=1111111 for its full dwell time.
REQ-024 Invalid codes SHALL NOT count as zero for blanking.
REQ-025 With blank_ceros=0, no digit SHALL be blanked.
REQ-026 cargar on the same edge as a tick SHALL advance the state; the new data SHALL appear in the next registered output.
REQ-027 REFRESH_DIV=1 SHALL tick every cycle, so the state advances every edge.

Reset
REQ-028 On an edge with reset=1: prescaler=0, state=UNOS, holding registers=0, an=1111, seg=1111111, digito_activo=0.
REQ-029 Reset SHALL override cargar and tick on the same edge.
REQ-030 On the first edge with reset=0: an=1110, seg=1000000 (units 0, never blanked).
REQ-031 Reset asserted mid-scan SHALL abort the scan and restart at UNOS with zeroed data.

Verification (REFRESH_DIV=4)
REQ-032 Reset 2 cycles, release -> an=1111/seg=1111111 during reset; first edge after release gives an=1110, seg=1000000.
REQ-033 cargar pulse with cientos=2, dieces=5, unos=5 -> repeating sequence, each held 4 cycles: an=1110/seg=0010010; an=1101/seg=0010010; an=1011/seg=0100100.
REQ-034 blank_ceros=1, load 0,0,7 -> hundreds and tens slots: an=1111, seg=1111111; units slot: an=1110, seg=1111000; same load with blank_ceros=0 -> tens and hundreds show 1000000.
REQ-035 Load unos=4'hA -> units slot seg=0111111; with blank_ceros=1 and 0,0,A loaded, the units slot still shows the dash.
REQ-036 Assert reset while digito_activo=2 -> next output an=1111; after release, units slot shows 1000000 and the old data is gone.
REQ-037 cargar of new data on a tick edge -> state advances and the next output uses the new digit; no cycle shows mixed or stale data for that slot.
